// File: rtl/param_window_fifo_pkg.sv
// ---------------------------------------------------------------------------
// window_pkg
//   Shared parameter defaults and pointer helpers for the sliding-window byte
//   FIFO (param_window_fifo) and its storage ring (byte_ring).
//
//   Contents:
//     DEF_*      default values for the block parameters
//     wrap_add   (ptr + inc) mod depth, for ptr < depth and inc <= depth
//     ptr_bits   address width for a ring of 'depth' entries (min 1)
//     cnt_bits   width of an occupancy counter that can hold 0..depth
// ---------------------------------------------------------------------------
package window_pkg;

  localparam int DEF_BYTE_W   = 8;
  localparam int DEF_IN_BYTES = 8;
  localparam int DEF_WIN      = 3;
  localparam int DEF_STRIDE   = 1;
  localparam int DEF_DEPTH    = 16;

  // Single conditional subtract instead of a modulo: the depth need not be a
  // power of two, and callers never advance by more than one full lap.
  function automatic int unsigned wrap_add(input int unsigned ptr,
                                           input int unsigned inc,
                                           input int unsigned depth);
    int unsigned sum;
    sum = ptr + inc;
    return (sum >= depth) ? (sum - depth) : sum;
  endfunction

  function automatic int unsigned ptr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_bits(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/param_window_fifo_if.sv
// ---------------------------------------------------------------------------
// param_window_fifo_if
//   Input and output handshake bundle of the sliding-window byte FIFO.
//
//   Signals:
//     in_data    IN_BYTES*BYTE_W  byte k in bits [k*BYTE_W +: BYTE_W]
//     in_nbytes  valid lanes 0..n-1 of in_data (values above IN_BYTES clamp)
//     in_valid / in_ready         input handshake
//     out_data   WIN*BYTE_W       window, oldest byte in lane 0
//     out_valid / out_ready       output handshake
//
//   Modports:
//     slave   the FIFO itself
//     master  the environment (producer of input words, consumer of windows)
// ---------------------------------------------------------------------------
interface param_window_fifo_if
  import window_pkg::*;
#(
  parameter int BYTE_W   = DEF_BYTE_W,
  parameter int IN_BYTES = DEF_IN_BYTES,
  parameter int WIN      = DEF_WIN
) ();

  logic [IN_BYTES*BYTE_W-1:0]      in_data;
  logic [$clog2(IN_BYTES+1)-1:0]   in_nbytes;
  logic                            in_valid;
  logic                            in_ready;
  logic [WIN*BYTE_W-1:0]           out_data;
  logic                            out_valid;
  logic                            out_ready;

  modport slave (
    input  in_data,
    input  in_nbytes,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_data,
    output in_nbytes,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/param_window_fifo_byte_ring.sv
// ---------------------------------------------------------------------------
// byte_ring
//   Circular byte storage for param_window_fifo. Scatters up to IN_BYTES
//   lanes of one input word to consecutive (wrapping) addresses starting at
//   wr_ptr, and gathers WIN consecutive (wrapping) bytes starting at rd_ptr.
//   Reads are combinational from the storage registers, so a byte written on
//   an edge is visible on rd_data right after that edge.
//
//   Ports:
//     clk       rising-edge clock
//     reset_n   asynchronous active-low reset, clears every byte to 0
//     wr_en     write the first wr_n lanes of wr_data this cycle
//     wr_ptr    address receiving lane 0
//     wr_n      number of lanes to write (0..IN_BYTES)
//     wr_data   input lanes, lane k in bits [k*BYTE_W +: BYTE_W]
//     rd_ptr    address of the oldest byte of the window
//     rd_data   window, lane k = mem[(rd_ptr + k) mod DEPTH]
// ---------------------------------------------------------------------------
module byte_ring
  import window_pkg::*;
#(
  parameter int BYTE_W   = DEF_BYTE_W,
  parameter int IN_BYTES = DEF_IN_BYTES,
  parameter int WIN      = DEF_WIN,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int PTR_W    = ptr_bits(DEPTH),
  parameter int NB_W     = $clog2(IN_BYTES + 1)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [PTR_W-1:0]           wr_ptr,
  input  logic [NB_W-1:0]            wr_n,
  input  logic [IN_BYTES*BYTE_W-1:0] wr_data,
  input  logic [PTR_W-1:0]           rd_ptr,
  output logic [WIN*BYTE_W-1:0]      rd_data
);

  logic [BYTE_W-1:0] mem_reg [DEPTH];

  // Per-address write decode
  logic [DEPTH-1:0]  hit;
  logic [BYTE_W-1:0] wr_byte [DEPTH];

  // Which input lane lands on 'addr' when lane 0 goes to 'base'.
  function automatic int unsigned lane_of(input int unsigned addr,
                                          input int unsigned base);
    return (addr >= base) ? (addr - base) : (addr + DEPTH - base);
  endfunction

  // Scatter: every address works out independently which lane (if any)
  // it takes, so no barrel shifter is needed on the write side.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_scatter
      assign hit[gi] = wr_en && (lane_of(gi, 32'(wr_ptr)) < 32'(wr_n));
      assign wr_byte[gi] = (lane_of(gi, 32'(wr_ptr)) < IN_BYTES)
                         ? wr_data[lane_of(gi, 32'(wr_ptr))*BYTE_W +: BYTE_W]
                         : '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem_reg[a] <= '0;
      end
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        if (hit[a]) begin
          mem_reg[a] <= wr_byte[a];
        end
      end
    end
  end

  // Gather: window lane k reads the k-th byte after the read pointer.
  generate
    for (gi = 0; gi < WIN; gi++) begin : g_gather
      assign rd_data[gi*BYTE_W +: BYTE_W] =
        mem_reg[PTR_W'(wrap_add(32'(rd_ptr), gi, DEPTH))];
    end
  endgenerate

endmodule

// File: rtl/param_window_fifo.sv
// ---------------------------------------------------------------------------
// param_window_fifo
//   Byte-granular FIFO that accepts words of up to IN_BYTES bytes and
//   presents a sliding window of WIN consecutive bytes. Each accepted window
//   retires STRIDE bytes. Storage is a circular buffer of DEPTH bytes with a
//   read pointer, a write pointer and an explicit occupancy counter.
//
//   Ports:
//     clk        rising-edge clock
//     reset_n    asynchronous active-low reset: empties the FIFO, clears data
//     row_clear  synchronous discard of all buffered bytes; wins over any
//                push or pop in the same cycle
//     bus        param_window_fifo_if.slave (input word + output window)
//     count      bytes currently held
//
//   Behaviour:
//     in_ready  = (DEPTH - count >= IN_BYTES), from the count register only
//     out_valid = (count >= WIN)
//     push      = in_valid & in_ready, writes min(in_nbytes, IN_BYTES) bytes
//     pop       = out_valid & out_ready, retires STRIDE bytes
//   Push and pop are independent and may happen in the same cycle. Bytes
//   left over below WIN simply wait for more input or a row_clear.
// ---------------------------------------------------------------------------
module param_window_fifo
  import window_pkg::*;
#(
  parameter int BYTE_W   = DEF_BYTE_W,
  parameter int IN_BYTES = DEF_IN_BYTES,
  parameter int WIN      = DEF_WIN,
  parameter int STRIDE   = DEF_STRIDE,
  parameter int DEPTH    = DEF_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           row_clear,
  param_window_fifo_if.slave             bus,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = ptr_bits(DEPTH);
  localparam int CNT_W = cnt_bits(DEPTH);
  localparam int NB_W  = $clog2(IN_BYTES + 1);

  logic [PTR_W-1:0] rptr_reg,  rptr_next;
  logic [PTR_W-1:0] wptr_reg,  wptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [NB_W-1:0]  n_eff;
  logic             push;
  logic             pop;
  logic             wr_en;

  // in_nbytes can encode more than IN_BYTES; anything beyond the lane count
  // means "the whole word".
  assign n_eff = (bus.in_nbytes > NB_W'(IN_BYTES)) ? NB_W'(IN_BYTES)
                                                   : bus.in_nbytes;

  // Both flags come from the count register alone, so neither handshake has
  // a combinational path from the opposite side of the FIFO.
  assign bus.in_ready  = (count_reg <= CNT_W'(DEPTH - IN_BYTES));
  assign bus.out_valid = (count_reg >= CNT_W'(WIN));

  // A zero-byte push is a no-op; excluding it here keeps the datapath idle.
  assign push  = bus.in_valid && bus.in_ready && (n_eff != '0);
  assign pop   = bus.out_valid && bus.out_ready;
  assign wr_en = push && !row_clear;

  always_comb begin
    rptr_next  = rptr_reg;
    wptr_next  = wptr_reg;
    count_next = count_reg;
    if (row_clear) begin
      rptr_next  = '0;
      wptr_next  = '0;
      count_next = '0;
    end else begin
      if (push) begin
        wptr_next = PTR_W'(wrap_add(32'(wptr_reg), 32'(n_eff), DEPTH));
      end
      if (pop) begin
        rptr_next = PTR_W'(wrap_add(32'(rptr_reg), STRIDE, DEPTH));
      end
      // Push admits at most DEPTH-count bytes and pop needs count >= WIN
      // >= STRIDE, so this never over- or underflows.
      count_next = count_reg
                 + (push ? CNT_W'(n_eff)  : CNT_W'(0))
                 - (pop  ? CNT_W'(STRIDE) : CNT_W'(0));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rptr_reg  <= '0;
      wptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      rptr_reg  <= rptr_next;
      wptr_reg  <= wptr_next;
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

  byte_ring #(
    .BYTE_W   (BYTE_W),
    .IN_BYTES (IN_BYTES),
    .WIN      (WIN),
    .DEPTH    (DEPTH),
    .PTR_W    (PTR_W),
    .NB_W     (NB_W)
  ) u_ring (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_ptr  (wptr_reg),
    .wr_n    (n_eff),
    .wr_data (bus.in_data),
    .rd_ptr  (rptr_reg),
    .rd_data (bus.out_data)
  );

endmodule
